// File: rtl/pwm_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pwm_sequencer_pkg                                      |
// | Description : Shared sequencer state encoding and step-entry layout. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pwm_sequencer_pkg;

  // Sequencer states; LOAD and NEXT are single-cycle timer (re)latch slots
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEXT = 2'd3
  } seq_state_t;

  // Step entry packed LSB first: {last, reps, cmp, top, prescaler}
  localparam int ENTRY_PSC_LSB = 0;

  function automatic int entry_top_lsb(input int pb);
    return pb;
  endfunction

  function automatic int entry_cmp_lsb(input int pb, input int tb);
    return pb + tb;
  endfunction

  function automatic int entry_reps_lsb(input int pb, input int tb);
    return pb + 2 * tb;
  endfunction

  function automatic int entry_last_pos(input int pb, input int tb, input int rb);
    return pb + 2 * tb + rb;
  endfunction

  function automatic int entry_width(input int pb, input int tb, input int rb);
    return pb + 2 * tb + rb + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sequencer_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pwm_sequencer_timer                                    |
// | Description : Prescaled up-counting PWM timer. Parameters are        |
// |               latched on the first go cycle and on each relatch.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pwm_sequencer_timer #(
  parameter int PRESCALER_BITS = 8,
  parameter int TIMER_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic                      relatch,
  input  logic [PRESCALER_BITS-1:0] prescaler_cnt,
  input  logic [TIMER_BITS-1:0]     top_cnt,
  input  logic [TIMER_BITS-1:0]     cmp_cnt,
  output logic                      pwm,
  output logic                      cmp_match,
  output logic                      top_match,
  output logic [TIMER_BITS-1:0]     counter
);

  logic [PRESCALER_BITS-1:0] r_psc_lat;
  logic [PRESCALER_BITS-1:0] r_psc;
  logic [TIMER_BITS-1:0]     r_top_lat;
  logic [TIMER_BITS-1:0]     r_cmp_lat;
  logic [TIMER_BITS-1:0]     r_cnt;
  logic                      r_active;
  logic                      w_on;

  // Latch on start/relatch (count restarts at 0), otherwise prescale then count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc_lat <= '0;
      r_top_lat <= '0;
      r_cmp_lat <= '0;
      r_psc     <= '0;
      r_cnt     <= '0;
      r_active  <= 1'b0;
    end else if (!go) begin
      r_psc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (!r_active || relatch) begin
      r_psc_lat <= prescaler_cnt;
      r_top_lat <= top_cnt;
      r_cmp_lat <= cmp_cnt;
      r_psc     <= '0;
      r_cnt     <= '0;
      r_active  <= 1'b1;
    end else if (r_psc == r_psc_lat) begin
      r_psc <= '0;
      r_cnt <= (r_cnt == r_top_lat) ? '0 : r_cnt + TIMER_BITS'(1);
    end else begin
      r_psc <= r_psc + PRESCALER_BITS'(1);
    end
  end

  // Outputs are forced low whenever the timer is not enabled and latched
  assign w_on      = go & r_active;
  assign pwm       = w_on & (r_cnt <= r_cmp_lat);
  assign cmp_match = w_on & (r_cnt == r_cmp_lat);
  assign top_match = w_on & (r_cnt == r_top_lat);
  assign counter   = w_on ? r_cnt : '0;

endmodule
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pwm_sequencer                                          |
// | Description : Steps a PWM timer through a table of entries, each     |
// |               running reps+1 timer periods, with optional looping.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter  int PRESCALER_BITS = 8,
  parameter  int TIMER_BITS     = 16,
  parameter  int DEPTH          = 8,
  parameter  int REP_BITS       = 8,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [PRESCALER_BITS-1:0] cfg_prescaler,
  input  logic [TIMER_BITS-1:0]     cfg_top,
  input  logic [TIMER_BITS-1:0]     cfg_cmp,
  input  logic [REP_BITS-1:0]       cfg_reps,
  input  logic                      cfg_last,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  output logic                      busy,
  output logic [AW-1:0]             step_idx,
  output logic                      step_done,
  output logic                      seq_done,
  output logic                      pwm,
  output logic                      cmp_match,
  output logic                      top_match,
  output logic [TIMER_BITS-1:0]     counter
);

  localparam int c_ew       = entry_width(PRESCALER_BITS, TIMER_BITS, REP_BITS);
  localparam int c_top_lsb  = entry_top_lsb(PRESCALER_BITS);
  localparam int c_cmp_lsb  = entry_cmp_lsb(PRESCALER_BITS, TIMER_BITS);
  localparam int c_reps_lsb = entry_reps_lsb(PRESCALER_BITS, TIMER_BITS);
  localparam int c_last_pos = entry_last_pos(PRESCALER_BITS, TIMER_BITS, REP_BITS);

  seq_state_t                r_state;
  logic                      r_go;
  logic                      r_relatch;
  logic [AW-1:0]             r_step_idx;
  logic [REP_BITS-1:0]       r_rep_cnt;
  logic [PRESCALER_BITS-1:0] r_pc;
  logic                      r_step_done;
  logic                      r_seq_done;
  logic [c_ew-1:0]           r_table [DEPTH];

  logic [c_ew-1:0]           w_wr_entry;
  logic [c_ew-1:0]           w_entry;
  logic [PRESCALER_BITS-1:0] w_psc;
  logic [TIMER_BITS-1:0]     w_top;
  logic [TIMER_BITS-1:0]     w_cmp;
  logic [REP_BITS-1:0]       w_reps;
  logic                      w_last;
  logic                      w_is_last;
  logic                      w_period_end;
  logic [TIMER_BITS-1:0]     w_counter;

  // Pack the configuration inputs into the shared entry layout
  always_comb begin
    w_wr_entry                                   = '0;
    w_wr_entry[ENTRY_PSC_LSB +: PRESCALER_BITS] = cfg_prescaler;
    w_wr_entry[c_top_lsb +: TIMER_BITS]          = cfg_top;
    w_wr_entry[c_cmp_lsb +: TIMER_BITS]          = cfg_cmp;
    w_wr_entry[c_reps_lsb +: REP_BITS]           = cfg_reps;
    w_wr_entry[c_last_pos]                       = cfg_last;
  end

  // Step table in flops; only writable while idle so a running step never changes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_table[cfg_addr] <= w_wr_entry;
    end
  end

  assign w_entry   = r_table[r_step_idx];
  assign w_psc     = w_entry[ENTRY_PSC_LSB +: PRESCALER_BITS];
  assign w_top     = w_entry[c_top_lsb +: TIMER_BITS];
  assign w_cmp     = w_entry[c_cmp_lsb +: TIMER_BITS];
  assign w_reps    = w_entry[c_reps_lsb +: REP_BITS];
  assign w_last    = w_entry[c_last_pos];
  // The final table slot always terminates the pass
  assign w_is_last = w_last | (r_step_idx == AW'(DEPTH - 1));

  // r_pc mirrors the timer prescaler so the period end is known without peeking inside
  assign w_period_end = (r_state == ST_RUN) && (r_pc == w_psc) && (w_counter == w_top);

  // Sequencer FSM with registered control and pulse outputs; stop overrides everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_go        <= 1'b0;
      r_relatch   <= 1'b0;
      r_step_idx  <= '0;
      r_rep_cnt   <= '0;
      r_pc        <= '0;
      r_step_done <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      r_seq_done  <= 1'b0;
      if (stop && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_go      <= 1'b0;
        r_relatch <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop) begin
              r_state    <= ST_LOAD;
              r_go       <= 1'b1;
              r_step_idx <= '0;
              r_rep_cnt  <= '0;
            end
          end
          ST_LOAD: begin
            r_state <= ST_RUN;
            r_pc    <= '0;
          end
          ST_RUN: begin
            r_pc <= (r_pc == w_psc) ? '0 : r_pc + PRESCALER_BITS'(1);
            if (w_period_end) begin
              if (r_rep_cnt < w_reps) begin
                r_rep_cnt <= r_rep_cnt + REP_BITS'(1);
              end else begin
                r_step_done <= 1'b1;
                r_rep_cnt   <= '0;
                if (!w_is_last) begin
                  r_state    <= ST_NEXT;
                  r_relatch  <= 1'b1;
                  r_step_idx <= r_step_idx + AW'(1);
                end else if (loop) begin
                  r_state    <= ST_NEXT;
                  r_relatch  <= 1'b1;
                  r_step_idx <= '0;
                end else begin
                  r_state    <= ST_IDLE;
                  r_go       <= 1'b0;
                  r_seq_done <= 1'b1;
                end
              end
            end
          end
          ST_NEXT: begin
            r_state   <= ST_RUN;
            r_relatch <= 1'b0;
            r_rep_cnt <= '0;
            r_pc      <= '0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_go    <= 1'b0;
          end
        endcase
      end
    end
  end

  pwm_sequencer_timer #(
    .PRESCALER_BITS (PRESCALER_BITS),
    .TIMER_BITS     (TIMER_BITS)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (r_go),
    .relatch       (r_relatch),
    .prescaler_cnt (w_psc),
    .top_cnt       (w_top),
    .cmp_cnt       (w_cmp),
    .pwm           (pwm),
    .cmp_match     (cmp_match),
    .top_match     (top_match),
    .counter       (w_counter)
  );

  assign counter   = w_counter;
  assign busy      = (r_state != ST_IDLE);
  assign step_idx  = r_step_idx;
  assign step_done = r_step_done;
  assign seq_done  = r_seq_done;

endmodule
`default_nettype wire
